// File: rtl/core_activity_monitor.sv
// rtl/core_activity_monitor.sv - per-core PDES event tracker with LP-conflict and lookahead stalls
// Holds {LP id, time} for each active core and stalls cores whose commit could break causal order.
module core_activity_monitor #(
  parameter int NUM_CORE  = 4,
  parameter int NUM_LP    = 8,
  parameter int TIME_WID  = 16,
  parameter int MSG_WID   = 32,
  parameter int LOOKAHEAD = 0,
  localparam int NB_CORE  = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1,
  localparam int NB_LP    = (NUM_LP > 1) ? $clog2(NUM_LP) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_vld,
  input  logic [NB_CORE-1:0]  start_core,
  input  logic [MSG_WID-1:0]  start_msg,
  input  logic                fin_vld,
  input  logic [NB_CORE-1:0]  fin_core,
  output logic [NUM_CORE-1:0] stall,
  output logic [TIME_WID-1:0] min_time,
  output logic                min_vld,
  output logic [NB_CORE:0]    active_cnt,
  output logic                err_dbl_start,
  output logic                err_bad_fin
);
  localparam bit                WIN_EN = (LOOKAHEAD > 0);
  localparam logic [TIME_WID:0] WIN    = (TIME_WID+1)'(LOOKAHEAD);

  logic [NUM_CORE-1:0] active;
  logic [NB_LP-1:0]    lp [NUM_CORE];
  logic [TIME_WID-1:0] tm [NUM_CORE];

  logic [NB_LP-1:0]    msg_lp;
  logic [TIME_WID-1:0] msg_tm;
  logic [NUM_CORE-1:0] start_hit;
  logic [NUM_CORE-1:0] fin_hit;
  logic                dbl_hit;
  logic                bad_hit;
  logic [TIME_WID:0]   win_lim;

  assign msg_lp = start_msg[TIME_WID+NB_LP-1:TIME_WID];
  assign msg_tm = start_msg[TIME_WID-1:0];

  generate
    if (MSG_WID > TIME_WID + NB_LP) begin : g_spare
      logic unused_msg;
      assign unused_msg = ^start_msg[MSG_WID-1:TIME_WID+NB_LP];
    end
  endgenerate

  always_comb begin
    start_hit = '0;
    fin_hit   = '0;
    dbl_hit   = 1'b0;
    bad_hit   = 1'b0;
    for (int i = 0; i < NUM_CORE; i++) begin
      start_hit[i] = start_vld && (start_core == NB_CORE'(i));
      fin_hit[i]   = fin_vld && (fin_core == NB_CORE'(i));
      // same-core finish retires the old event before the new start, so neither flag fires
      if (start_hit[i] && active[i] && !fin_hit[i]) dbl_hit = 1'b1;
      if (fin_hit[i] && !active[i] && !start_hit[i]) bad_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active        <= '0;
      err_dbl_start <= 1'b0;
      err_bad_fin   <= 1'b0;
      for (int i = 0; i < NUM_CORE; i++) begin
        lp[i] <= '0;
        tm[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORE; i++) begin
        if (start_hit[i]) begin
          active[i] <= 1'b1;
          lp[i]     <= msg_lp;
          tm[i]     <= msg_tm;
        end else if (fin_hit[i]) begin
          active[i] <= 1'b0;
        end
      end
      if (dbl_hit) err_dbl_start <= 1'b1;
      if (bad_hit) err_bad_fin   <= 1'b1;
    end
  end

  always_comb begin
    min_vld    = 1'b0;
    min_time   = '0;
    active_cnt = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      if (active[i]) begin
        active_cnt = active_cnt + (NB_CORE+1)'(1);
        if (!min_vld || tm[i] < min_time) min_time = tm[i];
        min_vld = 1'b1;
      end
    end
  end

  assign win_lim = {1'b0, min_time} + WIN;

  always_comb begin
    stall = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      for (int j = 0; j < NUM_CORE; j++) begin
        // lower index wins equal-time ties so one contender always proceeds
        if (j != i && active[i] && active[j] && lp[j] == lp[i] &&
            (tm[j] < tm[i] || (tm[j] == tm[i] && j < i)))
          stall[i] = 1'b1;
      end
      if (WIN_EN && active[i] && ({1'b0, tm[i]} > win_lim)) stall[i] = 1'b1;
    end
  end
endmodule
